// File: rtl/lamp_request_arbiter.sv
// Round-robin arbiter sharing one lamp driver between NUM_REQ command sources,
// with a post-command hold-off window and an inactivity auto-off timer.
//
// state  | meaning
// IDLE   | arbitrating requesters, or launching an auto-off when the timer expires
// ISSUE  | lamp command presented on the valid/ready handshake
// HOLD   | hold-off after a completed command, no requests accepted
module lamp_request_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int TMR_W       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_on,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           lamp_cmd_valid,
    output logic                           lamp_cmd_on,
    input  logic                           lamp_cmd_ready,
    output logic                           lamp_on,
    output logic [$clog2(NUM_REQ+1)-1:0]   grant_id,
    input  logic [TMR_W-1:0]               auto_off_cycles,
    output logic                           busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = $clog2(NUM_REQ + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               cmd_q, cmd_d;
    logic               valid_q, valid_d;
    logic               lamp_on_q, lamp_on_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      cand;
    logic               expired;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign expired = lamp_on_q && (timer_q == '0) && (auto_off_cycles != '0);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        cmd_d       = cmd_q;
        valid_d     = valid_q;
        lamp_on_d   = lamp_on_q;
        grant_id_d  = grant_id_q;
        req_ready_d = '0;
        timer_d     = (lamp_on_q && timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;

        case (state_q)
            S_IDLE: begin
                // The cycle carrying a ready pulse is the requester's accept cycle; its
                // valid is still high, so arbitration is skipped to avoid a double grant.
                if (req_ready_q == '0) begin
                    if (found) begin
                        req_ready_d = NUM_REQ'(1) << winner;
                        rr_ptr_d    = winner;
                        grant_id_d  = GW'(winner);
                        cmd_d       = req_on[winner];
                        timer_d     = req_on[winner] ? auto_off_cycles : '0;
                        if (req_on[winner] != lamp_on_q) begin
                            valid_d = 1'b1;
                            state_d = S_ISSUE;
                        end
                    end else if (expired) begin
                        cmd_d      = 1'b0;
                        grant_id_d = GW'(NUM_REQ);
                        valid_d    = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (lamp_cmd_ready) begin
                    lamp_on_d = cmd_q;
                    valid_d   = 1'b0;
                    hold_d    = HW'(HOLD_CYCLES - 1);
                    state_d   = S_HOLD;
                    if (!cmd_q) timer_d = '0;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_IDLE;
                else              hold_d  = hold_q - HW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= PW'(NUM_REQ - 1);
            hold_q      <= '0;
            timer_q     <= '0;
            cmd_q       <= 1'b0;
            valid_q     <= 1'b0;
            lamp_on_q   <= 1'b0;
            grant_id_q  <= '0;
            req_ready_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            valid_q     <= valid_d;
            lamp_on_q   <= lamp_on_d;
            grant_id_q  <= grant_id_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign lamp_cmd_valid = valid_q;
    assign lamp_cmd_on    = cmd_q;
    assign lamp_on        = lamp_on_q;
    assign grant_id       = grant_id_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_lamp_request_arbiter.sv
// Directed and randomized checks of lamp_request_arbiter against a
// transaction-level model (round-robin pick, lamp state, timing by arithmetic).
module tb_lamp_request_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int TW   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_on, req_ready;
    logic          lamp_cmd_valid, lamp_cmd_on, lamp_cmd_ready, lamp_on, busy;
    logic [2:0]    grant_id;
    logic [TW-1:0] auto_off_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_lamp  = 1'b0;
    int last_grant = N - 1;

    lamp_request_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .TMR_W(TW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_on(req_on),
        .req_ready(req_ready), .lamp_cmd_valid(lamp_cmd_valid), .lamp_cmd_on(lamp_cmd_on),
        .lamp_cmd_ready(lamp_cmd_ready), .lamp_on(lamp_on), .grant_id(grant_id),
        .auto_off_cycles(auto_off_cycles), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_grant + k) % N;
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // One requester transaction: grant, optional lamp handshake after dly stall cycles, hold-off.
    task automatic transact(input logic [N-1:0] v, input logic [N-1:0] on, input int dly,
                            input bit hold_v, input string tag);
        int w, cnt;
        bit cmd, issue, stable, quiet;
        logic [N-1:0] oh;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 200) begin tick; cnt++; end
        w = pick(v);
        cmd = on[w];
        issue = (cmd != m_lamp);
        oh = '0;
        oh[w] = 1'b1;
        req_valid = v;
        req_on = on;
        cnt = 0;
        while (req_ready === '0 && cnt < 50) begin tick; cnt++; end
        chk({tag, "_ready"}, req_ready, oh);
        chk({tag, "_grant"}, grant_id, w);
        chk({tag, "_cmdvalid"}, lamp_cmd_valid, issue);
        if (issue) chk({tag, "_cmdon"}, lamp_cmd_on, cmd);
        last_grant = w;
        if (!hold_v) req_valid = '0;
        tick;
        chk({tag, "_pulse1"}, req_ready, 0);
        if (issue) begin
            stable = 1'b1;
            repeat (dly) begin
                if (lamp_cmd_valid !== 1'b1 || lamp_cmd_on !== cmd || req_ready !== '0) stable = 1'b0;
                tick;
            end
            chk({tag, "_stall"}, stable, 1);
            lamp_cmd_ready = 1'b1;
            tick;
            lamp_cmd_ready = 1'b0;
            m_lamp = cmd;
            chk({tag, "_lamp"}, lamp_on, m_lamp);
            chk({tag, "_cmddrop"}, lamp_cmd_valid, 0);
            cnt = 0;
            quiet = 1'b1;
            while (busy === 1'b1 && cnt < 200) begin
                if (req_ready !== '0) quiet = 1'b0;
                tick;
                cnt++;
            end
            chk({tag, "_holdlen"}, cnt, HOLD);
            chk({tag, "_holdquiet"}, quiet, 1);
        end else begin
            chk({tag, "_idlebusy"}, busy, 0);
            chk({tag, "_lampkeep"}, lamp_on, m_lamp);
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        reset = 1'b1;
        req_valid = '0;
        req_on = '0;
        lamp_cmd_ready = 1'b0;
        auto_off_cycles = '0;
        repeat (3) tick;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", lamp_cmd_valid, 0);
        chk("rst_on", lamp_cmd_on, 0);
        chk("rst_lamp", lamp_on, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick;

        transact(4'b0001, 4'b0001, 3, 1'b0, "t1");

        for (int i = 0; i < 5; i++)
            transact(4'b1111, m_lamp ? 4'b0000 : 4'b1111, i, 1'b1, "t2");
        req_valid = '0;

        // Auto-off: a redundant ON reloads the timer; expiry fires auto_off_cycles clocks later.
        auto_off_cycles = 16'd20;
        transact(4'b0001, 4'b0001, 0, 1'b0, "t4on");
        repeat (5) tick;
        transact(4'b0010, 4'b0010, 0, 1'b0, "t3red");
        cnt = 0;
        while (lamp_cmd_valid !== 1'b1 && cnt < 100) begin tick; cnt++; end
        chk("t4_autodelay", cnt, 20);
        chk("t4_autogrant", grant_id, N);
        chk("t4_autocmd", lamp_cmd_on, 0);
        chk("t4_autoready", req_ready, 0);
        repeat (2) tick;
        lamp_cmd_ready = 1'b1;
        tick;
        lamp_cmd_ready = 1'b0;
        m_lamp = 1'b0;
        chk("t4_autolamp", lamp_on, 0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin tick; cnt++; end

        auto_off_cycles = '0;
        transact(4'b1100, 4'b0100, 1, 1'b0, "t4dis");
        seen = 1'b0;
        repeat (1000) begin
            if (lamp_cmd_valid !== 1'b0) seen = 1'b1;
            tick;
        end
        chk("t4_noauto", seen, 0);
        chk("t4_stillon", lamp_on, 1);

        transact(4'b1000, 4'b0000, 50, 1'b0, "t5");

        req_valid = 4'b0001;
        req_on = 4'b0001;
        cnt = 0;
        while (req_ready === '0 && cnt < 50) begin tick; cnt++; end
        chk("t6_issue", lamp_cmd_valid, 1);
        req_valid = '0;
        #2 reset = 1'b1;
        #1;
        chk("t6_ready", req_ready, 0);
        chk("t6_valid", lamp_cmd_valid, 0);
        chk("t6_on", lamp_cmd_on, 0);
        chk("t6_lamp", lamp_on, 0);
        chk("t6_grant", grant_id, 0);
        chk("t6_busy", busy, 0);
        repeat (2) tick;
        reset = 1'b0;
        m_lamp = 1'b0;
        last_grant = N - 1;
        tick;
        transact(4'b1111, 4'b1111, 1, 1'b0, "t6_first");

        repeat (30) begin
            logic [N-1:0] v, o;
            v = N'($urandom_range(1, 15));
            o = N'($urandom_range(0, 15));
            transact(v, o, $urandom_range(0, 3), 1'b0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
